// File: rtl/bus_rr_sched.sv
// Round-robin scheduler moving packets from driver FIFOs to receive FIFOs over one shared bus.
// Optional feature macro: BUS_SCHED_BCAST_EN enables broadcast delivery to all endpoints except the source.
module bus_rr_sched #(
  parameter int          pckg_sz   = 16,
  parameter int          drvrs     = 4,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]                pop,
  output logic [drvrs-1:0]                push,
  output logic [pckg_sz-1:0]              D_push,
  output logic [3:0]                      gnt_id,
  output logic                            busy,
  output logic [15:0]                     xfer_cnt,
  output logic [15:0]                     drop_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [3:0]           last_gnt;
  logic [3:0]           gnt_nxt;
  logic [drvrs-1:0]     pop_nxt;
  logic [drvrs-1:0]     push_nxt;
  logic [pckg_sz-1:0]   head_p0;
  logic [7:0]           dest_p0;
  logic                 found;
  logic                 bcast_hit;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_id;
    pop_nxt   = '0;
    push_nxt  = '0;
    found     = 1'b0;
    bcast_hit = 1'b0;
    head_p0   = '0;
    for (int j = 0; j < drvrs; j++) begin
      if (gnt_id == 4'(j)) head_p0 = D_pop[j];
    end
    dest_p0 = head_p0[pckg_sz-1 -: 8];
`ifdef BUS_SCHED_BCAST_EN
    bcast_hit = (dest_p0 == broadcast);
`endif

    case (state)
      IDLE: begin
        // Search starts just past the last grant, so that driver has lowest priority.
        for (int k = 1; k <= drvrs; k++) begin
          for (int j = 0; j < drvrs; j++) begin
            if (!found && pndng[j] && (((int'(last_gnt) + k) % drvrs) == j)) begin
              found   = 1'b1;
              gnt_nxt = 4'(j);
            end
          end
        end
        if (found) begin
          state_nxt = POP;
          for (int j = 0; j < drvrs; j++) pop_nxt[j] = (gnt_nxt == 4'(j));
        end
      end
      POP: begin
        // Decode here so push/D_push come out of registers during PUSH.
        state_nxt = PUSH;
        for (int j = 0; j < drvrs; j++) begin
          if (bcast_hit) push_nxt[j] = (gnt_id != 4'(j));
          else           push_nxt[j] = (dest_p0 == 8'(j)) && (gnt_id != 4'(j));
        end
      end
      PUSH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---- registered outputs, grant history and counters ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      pop      <= '0;
      push     <= '0;
      D_push   <= '0;
      gnt_id   <= '0;
      last_gnt <= 4'(drvrs - 1);
      xfer_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      pop    <= pop_nxt;
      push   <= push_nxt;
      gnt_id <= gnt_nxt;
      if (state == POP) last_gnt <= gnt_id;
      if (|push_nxt) D_push <= head_p0;
      if (state == PUSH) begin
        if (|push) xfer_cnt <= sat_inc(xfer_cnt);
        else       drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bus_rr_sched.sv
// Directed bench for bus_rr_sched (drvrs=4, pckg_sz=16) with hand-computed expectations.
module tb_bus_rr_sched;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        pndng;
  logic [3:0][15:0]  d_pop;
  logic [3:0]        pop;
  logic [3:0]        push;
  logic [15:0]       d_push;
  logic [3:0]        gnt_id;
  logic              busy;
  logic [15:0]       xfer_cnt;
  logic [15:0]       drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  bus_rr_sched #(.pckg_sz(16), .drvrs(4), .broadcast(8'hFF)) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (d_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (d_push),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .xfer_cnt (xfer_cnt),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transfer from a single pending driver; checks grant, pop and push.
  task automatic one_xfer(input int drv, input logic [15:0] word,
                          input logic [3:0] exp_push, input logic [15:0] exp_dpush);
    logic [3:0] m;
    m = 4'b0001 << drv;
    pndng = m;
    d_pop[drv] = word;
    tick();
    chk("xfer_pop", {28'd0, pop}, {28'd0, m});
    chk("xfer_gnt", {28'd0, gnt_id}, drv);
    tick();
    pndng = 4'b0000;
    chk("xfer_push", {28'd0, push}, {28'd0, exp_push});
    chk("xfer_dpush", {16'd0, d_push}, {16'd0, exp_dpush});
    tick();
    chk("xfer_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [3:0] m;
    logic [3:0] pm;
    int drv;

    reset = 1'b0;
    pndng = 4'b1111;
    d_pop[0] = 16'h0100;
    d_pop[1] = 16'h0211;
    d_pop[2] = 16'h0322;
    d_pop[3] = 16'h0033;
    #1;
    tick(); tick(); tick();
    chk("rst_pop",    {28'd0, pop}, 32'd0);
    chk("rst_push",   {28'd0, push}, 32'd0);
    chk("rst_dpush",  {16'd0, d_push}, 32'd0);
    chk("rst_gnt",    {28'd0, gnt_id}, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_xfer",   {16'd0, xfer_cnt}, 32'd0);
    chk("rst_drop",   {16'd0, drop_cnt}, 32'd0);

    // Round robin with all drivers pending: grants 0,1,2,3,0, one pop every 3 cycles.
    reset = 1'b1;
    for (int g = 0; g < 5; g++) begin
      drv = g % 4;
      m  = 4'b0001 << drv;
      pm = 4'b0001 << ((drv + 1) % 4);
      tick();
      chk("rr_pop",   {28'd0, pop}, {28'd0, m});
      chk("rr_gnt",   {28'd0, gnt_id}, drv);
      chk("rr_busy",  {31'd0, busy}, 32'd1);
      tick();
      chk("rr_pop_off", {28'd0, pop}, 32'd0);
      chk("rr_push",  {28'd0, push}, {28'd0, pm});
      chk("rr_dpush", {16'd0, d_push}, {16'd0, d_pop[drv]});
      tick();
      chk("rr_push_off", {28'd0, push}, 32'd0);
    end
    pndng = 4'b0000;
    chk("rr_xfer", {16'd0, xfer_cnt}, 32'd5);
    tick();
    chk("idle_pop", {28'd0, pop}, 32'd0);

    // Single unicast from driver 2 to endpoint 1.
    one_xfer(2, 16'h01AB, 4'b0010, 16'h01AB);
    chk("uni_xfer",  {16'd0, xfer_cnt}, 32'd6);
    chk("uni_hold",  {16'd0, d_push}, 32'h01AB);

    // Drops: out-of-range destination, then self-addressed.
    one_xfer(3, 16'h05C1, 4'b0000, 16'h01AB);
    chk("drop1_cnt", {16'd0, drop_cnt}, 32'd1);
    one_xfer(3, 16'h0377, 4'b0000, 16'h01AB);
    chk("drop2_cnt", {16'd0, drop_cnt}, 32'd2);
    chk("drop_xfer", {16'd0, xfer_cnt}, 32'd6);

    // Broadcast from driver 1.
`ifdef BUS_SCHED_BCAST_EN
    one_xfer(1, 16'hFF3C, 4'b1101, 16'hFF3C);
    chk("bc_xfer", {16'd0, xfer_cnt}, 32'd7);
    chk("bc_drop", {16'd0, drop_cnt}, 32'd2);
`else
    one_xfer(1, 16'hFF3C, 4'b0000, 16'h01AB);
    chk("bc_xfer", {16'd0, xfer_cnt}, 32'd6);
    chk("bc_drop", {16'd0, drop_cnt}, 32'd3);
`endif

    // Reset asserted during the POP cycle discards the packet.
    pndng = 4'b0001;
    d_pop[0] = 16'h0299;
    tick();
    chk("mr_pop", {28'd0, pop}, 32'd1);
    reset = 1'b0;
    tick();
    chk("mr_pop0",  {28'd0, pop}, 32'd0);
    chk("mr_push0", {28'd0, push}, 32'd0);
    chk("mr_dpush", {16'd0, d_push}, 32'd0);
    chk("mr_gnt",   {28'd0, gnt_id}, 32'd0);
    chk("mr_busy",  {31'd0, busy}, 32'd0);
    chk("mr_xfer",  {16'd0, xfer_cnt}, 32'd0);
    chk("mr_drop",  {16'd0, drop_cnt}, 32'd0);
    reset = 1'b1;
    pndng = 4'b0000;
    tick();
    chk("mr_nopush", {28'd0, push}, 32'd0);
    chk("mr_idle",   {31'd0, busy}, 32'd0);

    // Saturation: preload the transfer counter just below full scale.
    force dut.xfer_cnt = 16'hFFFE;
    #1;
    release dut.xfer_cnt;
    one_xfer(0, 16'h0155, 4'b0010, 16'h0155);
    chk("sat_full", {16'd0, xfer_cnt}, 32'h0000FFFF);
    one_xfer(1, 16'h0266, 4'b0100, 16'h0266);
    chk("sat_hold", {16'd0, xfer_cnt}, 32'h0000FFFF);
    chk("sat_drop", {16'd0, drop_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_rr_sched.md
# bus_rr_sched

Round-robin transfer scheduler for the shared packet bus between `drvrs` driver FIFOs.
- Watches every driver FIFO's pending flag and grants one driver at a time.
- Pops the granted driver's head packet, decodes the destination byte and pushes the packet to the destination FIFO(s) over a single shared `D_push` bus.
- Sits between the driver-side FIFO interfaces (`pndng`/`pop`/`D_pop`) and the receive-side FIFO interfaces (`push`/`D_push`).
- Exposes transfer and drop counters for the scoreboard.

## Interface
Parameters:
- `pckg_sz`, 16: packet width in bits. Must be ≥ 9. Bits `[pckg_sz-1:pckg_sz-8]` hold the destination ID.
- `drvrs`, 4: number of drivers/endpoints, 2..16.
- `broadcast`, 8'hFF: destination ID meaning "all endpoints".

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low; 0 sampled at a rising edge resets the block.
- `pndng` in `[drvrs-1:0]`: per-driver FIFO not-empty. The head word is valid on `D_pop` while high.
- `D_pop` in `[drvrs-1:0][pckg_sz-1:0]`: per-driver FIFO head data.
- `pop` out `[drvrs-1:0]`: one-hot pop strobe, at most one bit high.
- `push` out `[drvrs-1:0]`: push strobe mask to receive FIFOs.
- `D_push` out `[pckg_sz-1:0]`: shared packet bus, valid while any `push` bit is high.
- `gnt_id` out `[3:0]`: index of the driver currently or last granted.
- `busy` out 1: high in any state other than IDLE.
- `xfer_cnt` out 16: delivered packets (a broadcast counts once); saturates at 16'hFFFF.
- `drop_cnt` out 16: dropped packets; saturates at 16'hFFFF.

## Operation
State machine IDLE → POP → PUSH → IDLE.

- **IDLE**
  - If `pndng != 0`: choose the first driver with `pndng` set, searching from `last_gnt+1` upward with wrap-around.
  - Register it in `gnt_id`, then go to POP.
  - Otherwise stay in IDLE.
- **POP**
  - Drive `pop[gnt_id]=1` for exactly this cycle.
  - Latch `D_pop[gnt_id]` into the packet register.
  - Set `last_gnt = gnt_id`, then go to PUSH.
  - The `pop` is issued even if `pndng[gnt_id]` has fallen; the FIFO contract keeps `pndng` high until popped.
- **PUSH**
  - Decode `dest = pkt[pckg_sz-1:pckg_sz-8]`.
  - If `dest < drvrs` and `dest != gnt_id`: `push[dest]=1`, `D_push=pkt`, increment `xfer_cnt`.
  - If `dest == broadcast` and `BUS_SCHED_BCAST_EN` is defined: `push = ~(1<<gnt_id)`, `D_push=pkt`, increment `xfer_cnt`.
  - Otherwise (out-of-range dest, self-addressed, or broadcast while disabled): `push=0`, increment `drop_cnt`.
  - Always return to IDLE.
- **Fairness:** after a grant to driver i, driver i has the lowest priority in the next arbitration. No driver waits more than `drvrs-1` grants.
- **Packet integrity:** `D_push` carries the packet unmodified, including the destination byte.

## Timing
- **Reset:** after a reset edge:
  - state = IDLE; `pop=0`, `push=0`, `D_push=0`, `gnt_id=0`, `busy=0`, `xfer_cnt=0`, `drop_cnt=0`.
  - `last_gnt = drvrs-1`, so driver 0 wins first.
- **Reset mid-transfer:** the packet in flight is discarded without push or count. Outputs reach reset values at that same edge.
- **Latency:**
  - `pndng` sampled high in IDLE at edge N.
  - `pop` high in cycle N..N+1.
  - `push`/`D_push` valid in cycle N+1..N+2.
  - Back in IDLE after edge N+2.
- **Throughput:** one packet per 3 cycles under continuous load. The next arbitration happens in the IDLE cycle following PUSH.
- **Output registration:** `pop`, `push`, `D_push` are registered outputs and never glitch within a cycle.
- **`D_push` hold:** `D_push` holds its last value when `push=0`.
- **New requests:** `pndng` bits that rise during POP/PUSH are considered only at the next IDLE.
- **Counters:** update at the edge ending PUSH and saturate rather than wrap.

## Configuration
- `BUS_SCHED_BCAST_EN` defined:
  - Destination `broadcast` pushes the packet to every endpoint except the source, in one cycle.
  - `xfer_cnt` increments by 1.
- Not defined:
  - Broadcast logic is compiled out; `broadcast` ID is treated as out of range.
  - The packet is dropped and `drop_cnt` increments.

## Test plan
- **Reset:** hold `reset=0` 3 cycles with all `pndng=1` → `pop=0`, `push=0`, counters 0. First grant after release is driver 0.
- **Single unicast:** `drvrs=4`; driver 2 head 16'h01AB → `pop=4'b0100` one cycle, next cycle `push=4'b0010` with `D_push=16'h01AB`; `xfer_cnt=1`.
- **Round-robin fairness:** all four `pndng` held high with valid dests → grant order 0,1,2,3,0. `pop` period is 3 cycles.
- **Drops:** dest 8'h05 (out of range), then dest equal to the source → `push` stays 0 both times; `drop_cnt=2`, `xfer_cnt` unchanged.
- **Broadcast from driver 1, head 16'hFF3C:**
  - With `BUS_SCHED_BCAST_EN`: `push=4'b1101`, `D_push=16'hFF3C`.
  - Without it: `push=0`, `drop_cnt` +1.
- **Mid-transfer reset and saturation:**
  - Assert reset in the POP cycle → no `push` follows; all outputs at reset values after that edge.
  - Preload `xfer_cnt` near 16'hFFFF via a long run → it stays at 16'hFFFF.
